b4sq_credit_return: RTL and testbench

//  Receive-side flow-control credit return for the ECP5 PCIe (B4SQ) bridge, VC0.

---
 rtl/b4sq_credit_return.sv | 191 +++++++++++++++++++
 tb/tb_b4sq_credit_return.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/b4sq_credit_return.sv
// b4sq_credit_return
//   Receive-side VC0 flow-control credit return for the ECP5 PCIe (B4SQ) bridge.
//   Each consumed TLP reported by the RX sink is converted into header/data
//   credits. These credits accumulate per class (posted, non-posted) and are
//   handed back to the PCIe core through 1-cycle *_processed strobes.
//
// Ports
//   i_clk, i_rst            core clock, synchronous active-high reset
//   i_fc_*_infinite         static: class advertised infinite, never returned
//   i_rel_valid/o_rel_ready consumed-TLP event handshake
//   i_rel_np/_has_data/_len_dw  event attributes (len 0 encodes 1024 DW)
//   o_ph/o_nph_processed    one header credit returned (pulse)
//   o_pd/o_npd_processed    *_num data credits returned (pulse), *_num 0 otherwise
//   o_ovf_err               sticky accumulator saturation flag
//   o_dbg_dstate            data-return FSM states {np, p}
//
// Handshake: an event is taken on a rising edge where i_rel_valid and
// o_rel_ready are both high; o_rel_ready is registered and does not depend
// on i_rel_valid.
module b4sq_credit_return #(
  parameter int ACC_W     = 12,
  parameter int D_THRESH  = 8,
  parameter int D_TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_fc_ph_infinite,
  input  logic       i_fc_pd_infinite,
  input  logic       i_fc_nph_infinite,
  input  logic       i_fc_npd_infinite,
  input  logic       i_rel_valid,
  output logic       o_rel_ready,
  input  logic       i_rel_np,
  input  logic       i_rel_has_data,
  input  logic [9:0] i_rel_len_dw,
  output logic       o_ph_processed,
  output logic       o_pd_processed,
  output logic [7:0] o_pd_num,
  output logic       o_nph_processed,
  output logic       o_npd_processed,
  output logic [7:0] o_npd_num,
  output logic       o_ovf_err,
  output logic [3:0] o_dbg_dstate
);

  typedef enum logic [1:0] {D_IDLE = 2'd0, D_WAIT = 2'd1, D_RET = 2'd2} dstate_e;

  localparam int TW = $clog2(D_TIMEOUT + 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [ACC_W-1:0] BP_LIMIT = ACC_W'((2 ** ACC_W) - 1 - 256);
  localparam logic [ACC_W-1:0] THRESH   = ACC_W'(D_THRESH);
  localparam logic [TW-1:0]    TMO_LAST = TW'(D_TIMEOUT - 1);

  // Index 0 = posted, 1 = non-posted.
  logic [1:0][ACC_W-1:0] hacc_q, hacc_d, dacc_q, dacc_d;
  logic [1:0][TW-1:0]    timer_q, timer_d;
  dstate_e               dstate_q [2];
  dstate_e               dstate_d [2];
  logic [1:0]            h_pulse_q, h_pulse_d, d_pulse_q, d_pulse_d;
  logic [1:0][7:0]       d_num_q, d_num_d;
  logic                  ready_q, ready_d, ovf_q, ovf_d;

  logic [1:0]       h_inf, d_inf;
  logic             rel_fire, hit;
  logic [10:0]      len_up;
  logic [8:0]       data_cred;
  logic [ACC_W:0]   h_sum, d_sum;
  logic [ACC_W-1:0] h_sat, d_sat;
  logic [7:0]       d_cap;

  assign h_inf    = {i_fc_nph_infinite, i_fc_ph_infinite};
  assign d_inf    = {i_fc_npd_infinite, i_fc_pd_infinite};
  assign rel_fire = i_rel_valid & ready_q;
  assign len_up   = {1'b0, i_rel_len_dw} + 11'd3;

  always_comb begin
    data_cred = '0;
    if (i_rel_has_data) begin
      data_cred = (i_rel_len_dw == '0) ? 9'd256 : len_up[10:2];
    end
  end

  always_comb begin
    hacc_d    = hacc_q;
    dacc_d    = dacc_q;
    timer_d   = timer_q;
    dstate_d  = dstate_q;
    h_pulse_d = '0;
    d_pulse_d = '0;
    d_num_d   = '0;
    ovf_d     = ovf_q;
    ready_d   = 1'b1;
    hit       = 1'b0;
    h_sum     = '0;
    d_sum     = '0;
    h_sat     = '0;
    d_sat     = '0;
    d_cap     = '0;
    for (int c = 0; c < 2; c++) begin
      hit   = rel_fire && (i_rel_np == (c == 1));
      // Returns are decided on acc + this cycle's add, so a new event
      // can be returned on the very next cycle.
      h_sum = {1'b0, hacc_q[c]} + {{ACC_W{1'b0}}, (hit && !h_inf[c])};
      d_sum = {1'b0, dacc_q[c]} +
              ((hit && !d_inf[c]) ? {{(ACC_W-8){1'b0}}, data_cred} : '0);
      if (h_sum[ACC_W] || d_sum[ACC_W]) ovf_d = 1'b1;
      h_sat = h_sum[ACC_W] ? ACC_MAX : h_sum[ACC_W-1:0];
      d_sat = d_sum[ACC_W] ? ACC_MAX : d_sum[ACC_W-1:0];
      d_cap = (d_sat > ACC_W'(255)) ? 8'hFF : d_sat[7:0];

      h_pulse_d[c] = (h_sat != '0);
      hacc_d[c]    = h_sat - {{(ACC_W-1){1'b0}}, h_pulse_d[c]};

      dacc_d[c] = d_sat;
      unique case (dstate_q[c])
        D_IDLE, D_WAIT: begin
          if (d_sat == '0) begin
            dstate_d[c] = D_IDLE;
            timer_d[c]  = '0;
          end else if (d_sat >= THRESH || timer_q[c] == TMO_LAST) begin
            dstate_d[c]  = D_RET;
            timer_d[c]   = '0;
            d_pulse_d[c] = 1'b1;
            d_num_d[c]   = d_cap;
            dacc_d[c]    = d_sat - {{(ACC_W-8){1'b0}}, d_cap};
          end else begin
            dstate_d[c] = D_WAIT;
            timer_d[c]  = timer_q[c] + 1'b1;
          end
        end
        D_RET: begin
          // A return capped at 255 keeps draining on consecutive cycles
          // until the accumulator is empty.
          timer_d[c] = '0;
          if (d_sat == '0) begin
            dstate_d[c] = D_IDLE;
          end else begin
            dstate_d[c]  = D_RET;
            d_pulse_d[c] = 1'b1;
            d_num_d[c]   = d_cap;
            dacc_d[c]    = d_sat - {{(ACC_W-8){1'b0}}, d_cap};
          end
        end
        default: begin
          dstate_d[c] = D_IDLE;
          timer_d[c]  = '0;
        end
      endcase

      // Leave room for one maximal (256-credit) event in every live class.
      if ((!h_inf[c] && hacc_d[c] > BP_LIMIT) || (!d_inf[c] && dacc_d[c] > BP_LIMIT)) begin
        ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hacc_q    <= '0;
      dacc_q    <= '0;
      timer_q   <= '0;
      h_pulse_q <= '0;
      d_pulse_q <= '0;
      d_num_q   <= '0;
      ready_q   <= 1'b1;
      ovf_q     <= 1'b0;
      for (int c = 0; c < 2; c++) dstate_q[c] <= D_IDLE;
    end else begin
      hacc_q    <= hacc_d;
      dacc_q    <= dacc_d;
      timer_q   <= timer_d;
      h_pulse_q <= h_pulse_d;
      d_pulse_q <= d_pulse_d;
      d_num_q   <= d_num_d;
      ready_q   <= ready_d;
      ovf_q     <= ovf_d;
      for (int c = 0; c < 2; c++) dstate_q[c] <= dstate_d[c];
    end
  end

  assign o_rel_ready     = ready_q;
  assign o_ph_processed  = h_pulse_q[0];
  assign o_nph_processed = h_pulse_q[1];
  assign o_pd_processed  = d_pulse_q[0];
  assign o_npd_processed = d_pulse_q[1];
  assign o_pd_num        = d_num_q[0];
  assign o_npd_num       = d_num_q[1];
  assign o_ovf_err       = ovf_q;
  assign o_dbg_dstate    = {dstate_q[1], dstate_q[0]};

endmodule

// File: tb/tb_b4sq_credit_return.sv
module tb_b4sq_credit_return;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared event attributes, per-DUT valid
  logic       rel_np = 1'b0, rel_has_data = 1'b0;
  logic [9:0] rel_len = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ph_inf = 1'b0, a_pd_inf = 1'b0;

  // DUT A: default parameters
  logic       a_ready, a_ph, a_pd, a_nph, a_npd, a_ovf;
  logic [7:0] a_pd_num, a_npd_num;
  logic [3:0] a_dbg;

  b4sq_credit_return dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_fc_ph_infinite(a_ph_inf), .i_fc_pd_infinite(a_pd_inf),
    .i_fc_nph_infinite(1'b0), .i_fc_npd_infinite(1'b0),
    .i_rel_valid(a_valid), .o_rel_ready(a_ready),
    .i_rel_np(rel_np), .i_rel_has_data(rel_has_data), .i_rel_len_dw(rel_len),
    .o_ph_processed(a_ph), .o_pd_processed(a_pd), .o_pd_num(a_pd_num),
    .o_nph_processed(a_nph), .o_npd_processed(a_npd), .o_npd_num(a_npd_num),
    .o_ovf_err(a_ovf), .o_dbg_dstate(a_dbg)
  );

  // DUT B: threshold out of reach so data accumulates until timeout
  logic       b_ready, b_ph, b_pd, b_nph, b_npd, b_ovf;
  logic [7:0] b_pd_num, b_npd_num;
  logic [3:0] b_dbg;

  b4sq_credit_return #(.ACC_W(12), .D_THRESH(4095), .D_TIMEOUT(200)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_fc_ph_infinite(1'b0), .i_fc_pd_infinite(1'b0),
    .i_fc_nph_infinite(1'b0), .i_fc_npd_infinite(1'b0),
    .i_rel_valid(b_valid), .o_rel_ready(b_ready),
    .i_rel_np(rel_np), .i_rel_has_data(rel_has_data), .i_rel_len_dw(rel_len),
    .o_ph_processed(b_ph), .o_pd_processed(b_pd), .o_pd_num(b_pd_num),
    .o_nph_processed(b_nph), .o_npd_processed(b_npd), .o_npd_num(b_npd_num),
    .o_ovf_err(b_ovf), .o_dbg_dstate(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observed-return counters, sampled on the falling edge.
  int cnt_ph, cnt_pd, sum_pd, cnt_nph, cnt_npd, a_ready_low, bad_num;
  int cnt_ph_b, sum_pd_b, b_ready_low;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_ph)  cnt_ph++;
      if (a_pd)  begin cnt_pd++; sum_pd += int'(a_pd_num); end
      if (a_nph) cnt_nph++;
      if (a_npd) cnt_npd++;
      if (!a_ready) a_ready_low++;
      if ((!a_pd && a_pd_num != 0) || (!a_npd && a_npd_num != 0)) bad_num++;
      if (b_ph) cnt_ph_b++;
      if (b_pd) sum_pd_b += int'(b_pd_num);
      if (!b_ready) b_ready_low++;
    end
  end

  task automatic clear_counts();
    cnt_ph = 0; cnt_pd = 0; sum_pd = 0; cnt_nph = 0; cnt_npd = 0;
    a_ready_low = 0; cnt_ph_b = 0; sum_pd_b = 0; b_ready_low = 0;
  endtask

  // ---------------- drivers ----------------
  // Presents one event to DUT A for one cycle; returns at the falling edge
  // right after the accepting rising edge.
  task automatic send_a(input logic np, input logic hd, input logic [9:0] len);
    @(negedge clk);
    a_valid = 1'b1; rel_np = np; rel_has_data = hd; rel_len = len;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  // Handshaked send to DUT B; ready is checked on the falling edge.
  task automatic send_b(input logic [9:0] len, output logic ok);
    int budget;
    ok = 1'b0;
    budget = 1000;
    @(negedge clk);
    b_valid = 1'b1; rel_np = 1'b0; rel_has_data = 1'b1; rel_len = len;
    while (!b_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (b_ready) begin
      ok = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pd_k;
    logic [7:0] pd_val;
    logic ok;
    int accepted_b, acc_at_drop;

    clear_counts();
    bad_num = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(a_ready), 1);
    check("rst_ph", 32'(a_ph), 0);
    check("rst_pd", 32'({a_pd, a_pd_num}), 0);
    check("rst_ovf", 32'(a_ovf), 0);
    check("rst_dbg", 32'(a_dbg), 0);
    rst = 1'b0;

    // 1: reset while data credits are pending
    send_a(1'b0, 1'b1, 10'd16);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_strobes", 32'({a_ph, a_pd, a_nph, a_npd}), 0);
    check("t1_ready", 32'(a_ready), 1);
    rst = 1'b0;
    clear_counts();
    repeat (100) @(negedge clk);
    check("t1_no_pd", 32'(cnt_pd), 0);
    check("t1_no_ph", 32'(cnt_ph), 0);

    // 2: posted MWr 16 DW -> 4 data credits after the timeout
    clear_counts();
    send_a(1'b0, 1'b1, 10'd16);
    check("t2_ph_n1", 32'(a_ph), 1);
    check("t2_pd_n1", 32'(a_pd), 0);
    pd_k = -1;
    pd_val = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (a_pd && pd_k < 0) begin
        pd_k = k;
        pd_val = a_pd_num;
      end
    end
    check("t2_pd_latency", 32'(pd_k), 63);
    check("t2_pd_num", 32'(pd_val), 4);
    check("t2_ph_count", 32'(cnt_ph), 1);
    check("t2_np_strobes", 32'(cnt_nph + cnt_npd), 0);

    // 3: three back-to-back MRd (no data)
    clear_counts();
    @(negedge clk);
    a_valid = 1'b1; rel_np = 1'b1; rel_has_data = 1'b0; rel_len = 10'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t3_nph_%0d", i), 32'(a_nph), 1);
    end
    a_valid = 1'b0;
    @(negedge clk);
    check("t3_nph_end", 32'(a_nph), 0);
    repeat (100) @(negedge clk);
    check("t3_nph_count", 32'(cnt_nph), 3);
    check("t3_npd_none", 32'(cnt_npd), 0);

    // 4: 1024 DW write -> 255 then 1 on consecutive cycles
    clear_counts();
    exp_q.push_back(8'd255);
    exp_q.push_back(8'd1);
    send_a(1'b0, 1'b1, 10'd0);
    check("t4_pd_a", 32'(a_pd), 1);
    check("t4_num_a", 32'(a_pd_num), 32'(exp_q.pop_front()));
    @(negedge clk);
    check("t4_pd_b", 32'(a_pd), 1);
    check("t4_num_b", 32'(a_pd_num), 32'(exp_q.pop_front()));
    @(negedge clk);
    check("t4_pd_c", 32'(a_pd), 0);
    repeat (80) @(negedge clk);
    check("t4_sum", 32'(sum_pd), 256);

    // 5: posted classes infinite
    a_ph_inf = 1'b1; a_pd_inf = 1'b1;
    clear_counts();
    @(negedge clk);
    a_valid = 1'b1; rel_np = 1'b0; rel_has_data = 1'b1; rel_len = 10'd64;
    repeat (10) @(negedge clk);
    a_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_ph", 32'(cnt_ph), 0);
    check("t5_pd", 32'(cnt_pd), 0);
    check("t5_ready_low", 32'(a_ready_low), 0);
    a_ph_inf = 1'b0; a_pd_inf = 1'b0;

    // 6: accumulate until backpressure, then drain on timeout (DUT B)
    clear_counts();
    accepted_b = 0;
    acc_at_drop = -1;
    for (int i = 0; i < 16; i++) begin
      send_b(10'd0, ok);
      if (ok) accepted_b++;
      if (!b_ready && acc_at_drop < 0) acc_at_drop = accepted_b;
    end
    check("t6_all_accepted", 32'(accepted_b), 16);
    check("t6_drop_point", 32'(acc_at_drop), 15);
    repeat (300) @(negedge clk);
    check("t6_ready_dropped", 32'(b_ready_low > 0), 1);
    check("t6_ovf", 32'(b_ovf), 0);
    check("t6_sum", 32'(sum_pd_b), 4096);
    check("t6_ph_count", 32'(cnt_ph_b), 16);
    check("t6_ready_end", 32'(b_ready), 1);

    check("num_zero_when_idle", 32'(bad_num), 0);
    check("a_ovf_end", 32'(a_ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
